// File: rtl/sram_bridge_s16_pkg.sv
// rtl/sram_bridge_s16_pkg.sv - shared S16X4 bus slave definitions
// Purpose: state encodings and byte-lane indices reused by the SRAM, ROM and
// I/O slaves on the S16X4 bus.
// Ports: none (package).
package sram_bridge_s16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } bus_state_t;

  // Byte-lane indices into stb_i: [1] = dq[15:8], [0] = dq[7:0].
  localparam int STB_HI = 1;
  localparam int STB_LO = 0;

endpackage

// File: rtl/sram_bridge_s16.sv
// rtl/sram_bridge_s16.sv - S16X4 bus slave driving an async 16-bit cellular RAM
// Purpose: turns a held cyc/stb/we request into a timed async SRAM cycle with
// SETUP_CYCLES of address/CE setup and WAIT_STATES of OE/WE strobe, then a
// single-cycle ack with registered read data.
// Ports:
//   clk_i, res_i            clock, synchronous active-high reset
//   adr_i, we_i, cyc_i,
//   stb_i, dat_i            CPU request (held until ack_o)
//   ack_o, dat_o            one-clock ack; read data valid only with ack_o
//   sram_adr_o, sram_*_n    SRAM address and active-low controls
//   sram_dq_o/_i/_oe        SRAM data out, data in, pad-buffer enable
module sram_bridge_s16
  import sram_bridge_s16_pkg::*;
#(
  parameter int WAIT_STATES  = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [14:0] adr_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic [1:0]  stb_i,
  input  logic [15:0] dat_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
  output logic [14:0] sram_adr_o,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe
);

  if (WAIT_STATES < 1 || WAIT_STATES > 255) begin : g_bad_wait_states
    $error("sram_bridge_s16: WAIT_STATES must be 1..255");
  end
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3) begin : g_bad_setup_cycles
    $error("sram_bridge_s16: SETUP_CYCLES must be 1..3");
  end

  // Counter reload values: the counter runs N-1 down to 0, one cycle each.
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD  = 8'(WAIT_STATES - 1);

  bus_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic        r_ack;
  logic [15:0] r_dat;
  logic [14:0] r_adr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_ub_n;
  logic        r_lb_n;
  logic [15:0] r_dq_o;
  logic        r_dq_oe;

  // Leave the access: after the single ack cycle, or when the CPU drops cyc_i
  // mid-access (abort, no ack).
  logic w_to_idle;
  assign w_to_idle = (r_state == ST_ACK) ||
                     (((r_state == ST_SETUP) || (r_state == ST_STROBE)) && !cyc_i);

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= 16'd0;
      r_adr   <= 15'd0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_dq_o  <= 16'd0;
      r_dq_oe <= 1'b0;
    end else if (w_to_idle) begin
      // Address is left as-is; only the controls and data path are released.
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_ack   <= 1'b0;
      r_dat   <= 16'd0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_dq_o  <= 16'd0;
      r_dq_oe <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cyc_i) begin
            if (stb_i != 2'b00) begin
              r_state <= ST_SETUP;
              r_cnt   <= SETUP_LOAD;
              r_we    <= we_i;
              r_adr   <= adr_i;
              r_ce_n  <= 1'b0;
              r_ub_n  <= ~stb_i[STB_HI];
              r_lb_n  <= ~stb_i[STB_LO];
              // dq_oe only ever rises for writes, so it can never overlap a
              // read's oe_n=0 window.
              r_dq_oe <= we_i;
              r_dq_o  <= we_i ? dat_i : 16'd0;
            end else begin
              // Null cycle: no lanes selected, ack without touching the SRAM.
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
              r_dat   <= 16'd0;
            end
          end
        end
        ST_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_STROBE;
            r_cnt   <= WAIT_LOAD;
            r_oe_n  <= r_we;
            r_we_n  <= ~r_we;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dat   <= r_we ? 16'd0 : sram_dq_i;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o      = r_ack;
  assign dat_o      = r_dat;
  assign sram_adr_o = r_adr;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_bridge_s16.sv
// tb/tb_sram_bridge_s16.sv - directed self-checking bench for sram_bridge_s16
module tb_sram_bridge_s16;

  logic        clk = 1'b0;
  logic        res;
  logic [14:0] adr;
  logic        we;
  logic        cyc;
  logic        cyc_s;
  logic [1:0]  stb;
  logic [15:0] dat;

  logic        ack;
  logic [15:0] dat_o;
  logic [14:0] s_adr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] dq_o;
  logic [15:0] dq_i;
  logic        dq_oe;

  logic        ack_a, ce_a, oe_a, we_a, ub_a, lb_a, dqoe_a;
  logic [15:0] dato_a, dqo_a;
  logic [14:0] adr_a;
  logic        ack_b, ce_b, oe_b, we_b, ub_b, lb_b, dqoe_b;
  logic [15:0] dato_b, dqo_b;
  logic [14:0] adr_b;
  logic [15:0] dq_sweep;

  logic [15:0] mem [0:32767];

  int n_pass  = 0;
  int n_total = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;

  sram_bridge_s16 dut (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we), .cyc_i(cyc),
    .stb_i(stb), .dat_i(dat), .ack_o(ack), .dat_o(dat_o),
    .sram_adr_o(s_adr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
    .sram_dq_o(dq_o), .sram_dq_i(dq_i), .sram_dq_oe(dq_oe)
  );

  sram_bridge_s16 #(.WAIT_STATES(1), .SETUP_CYCLES(3)) dut_a (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we), .cyc_i(cyc_s),
    .stb_i(stb), .dat_i(dat), .ack_o(ack_a), .dat_o(dato_a),
    .sram_adr_o(adr_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a),
    .sram_we_n(we_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a),
    .sram_dq_o(dqo_a), .sram_dq_i(dq_sweep), .sram_dq_oe(dqoe_a)
  );

  sram_bridge_s16 #(.WAIT_STATES(255), .SETUP_CYCLES(3)) dut_b (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we), .cyc_i(cyc_s),
    .stb_i(stb), .dat_i(dat), .ack_o(ack_b), .dat_o(dato_b),
    .sram_adr_o(adr_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b),
    .sram_we_n(we_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b),
    .sram_dq_o(dqo_b), .sram_dq_i(dq_sweep), .sram_dq_oe(dqoe_b)
  );

  assign dq_sweep = 16'hA5A5;

  // Async SRAM model: reads drive only while selected, otherwise a marker.
  assign dq_i = (!ce_n && !oe_n) ? mem[s_adr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[s_adr][15:8] = dq_o[15:8];
      if (!lb_n) mem[s_adr][7:0]  = dq_o[7:0];
    end
  end

  always @(negedge clk) begin
    if (dq_oe && !oe_n)   n_overlap++;
    if (dqoe_a && !oe_a)  n_overlap++;
    if (dqoe_b && !oe_b)  n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_ack, ack_c, ack_c2, low_cnt, leak;
  logic [15:0] ack_d, ack_d2;
  int first_a, first_b;

  initial begin
    res = 1'b1; adr = '0; we = 1'b0; cyc = 1'b0; cyc_s = 1'b0; stb = 2'b00; dat = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h7FF8] = 16'h1234;
    mem[15'h0010] = 16'h1122;
    mem[15'h0100] = 16'hAAAA;
    mem[15'h0101] = 16'h5555;
    tick(); tick();
    res = 1'b0;

    // Reset values
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_ctl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    chk("rst_dqoe", dq_oe, 0);
    chk("rst_dqo", dq_o, 0);
    chk("rst_adr", s_adr, 0);

    // Word read, default timing: ack expected in cycle 6 only
    adr = 15'h7FF8; stb = 2'b11; we = 1'b0; cyc = 1'b1;
    n_ack = 0; ack_c = 0; low_cnt = 0; leak = 0; ack_d = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        chk("rd_adr", s_adr, 15'h7FF8);
        chk("rd_ce", ce_n, 0);
      end
      if (!oe_n) low_cnt++;
      if (ack) begin
        n_ack++; ack_c = c; ack_d = dat_o; cyc = 1'b0;
      end else if (dat_o != 16'd0) leak++;
    end
    chk("rd_oe_cycles", low_cnt, 4);
    chk("rd_ack_count", n_ack, 1);
    chk("rd_ack_cycle", ack_c, 6);
    chk("rd_data", ack_d, 16'h1234);
    chk("rd_dat_leak", leak, 0);
    chk("rd_idle_ctl", {ce_n, oe_n, we_n}, 3'b111);

    // Upper-byte write
    adr = 15'h0010; stb = 2'b10; we = 1'b1; dat = 16'hBEEF; cyc = 1'b1;
    n_ack = 0; ack_c = 0; low_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        chk("wr_lanes", {ub_n, lb_n}, 2'b01);
        chk("wr_dqoe", dq_oe, 1);
        chk("wr_dqo", dq_o, 16'hBEEF);
      end
      if (!we_n) low_cnt++;
      if (ack) begin
        n_ack++; ack_c = c; cyc = 1'b0;
      end
    end
    chk("wr_we_cycles", low_cnt, 4);
    chk("wr_ack_count", n_ack, 1);
    chk("wr_ack_cycle", ack_c, 6);
    chk("wr_mem", mem[15'h0010], 16'hBE22);
    chk("wr_dqoe_off", dq_oe, 0);

    // Back-to-back reads: second request presented right after the first ack
    adr = 15'h0100; stb = 2'b11; we = 1'b0; cyc = 1'b1;
    n_ack = 0; ack_c = 0; ack_c2 = 0; ack_d = '0; ack_d2 = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack) begin
        n_ack++;
        if (n_ack == 1) begin
          ack_c = c; ack_d = dat_o; adr = 15'h0101;
        end else begin
          ack_c2 = c; ack_d2 = dat_o; cyc = 1'b0;
        end
      end
    end
    chk("b2b_ack_count", n_ack, 2);
    chk("b2b_ack1_cycle", ack_c, 6);
    chk("b2b_ack2_cycle", ack_c2, 13);
    chk("b2b_data1", ack_d, 16'hAAAA);
    chk("b2b_data2", ack_d2, 16'h5555);

    // Null cycle: ack in cycle 1, SRAM untouched
    stb = 2'b00; cyc = 1'b1;
    tick();
    chk("null_ack", ack, 1);
    chk("null_ce", ce_n, 1);
    chk("null_dat", dat_o, 0);
    cyc = 1'b0;
    tick();
    chk("null_ack_off", ack, 0);

    // Abort: drop cyc_i in the second strobe cycle (cycle 3)
    adr = 15'h0100; stb = 2'b11; we = 1'b0; cyc = 1'b1;
    tick(); tick(); tick();
    chk("abort_in_strobe", oe_n, 0);
    cyc = 1'b0;
    tick();
    chk("abort_ctl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      if (ack) n_ack++;
      tick();
    end
    chk("abort_no_ack", n_ack, 0);

    // Reset held for 2 clocks during a strobe write
    adr = 15'h0020; stb = 2'b11; we = 1'b1; dat = 16'h1357; cyc = 1'b1;
    tick(); tick(); tick();
    chk("rstw_in_strobe", we_n, 0);
    res = 1'b1;
    tick();
    chk("rstw_ctl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    chk("rstw_ack", ack, 0);
    chk("rstw_dqoe", dq_oe, 0);
    tick();
    res = 1'b0; cyc = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (!ce_n || !we_n || ack) low_cnt++;
    end
    chk("rstw_quiet", low_cnt, 0);

    // Parameter sweep: (WS=1,SU=3) -> cycle 5, (WS=255,SU=3) -> cycle 259
    adr = 15'h0100; stb = 2'b11; we = 1'b0; cyc_s = 1'b1;
    first_a = 0; first_b = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (ack_a && first_a == 0) first_a = c;
      if (ack_b && first_b == 0) begin
        first_b = c;
        break;
      end
    end
    cyc_s = 1'b0;
    tick(); tick(); tick();
    chk("sweep_ws1_cycle", first_a, 5);
    chk("sweep_ws255_cycle", first_b, 259);

    chk("no_dqoe_oe_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
